// File: rtl/fifo_to_between_if.sv
// Handshake bundle between the transmit FSM, its source FIFO and the remote receiver.
// The master side is the transmitter; the slave side is the FIFO/receiver environment.
interface fifo_to_between_if;
    logic       fifo_empty;
    logic [7:0] fifo_dout;
    logic       fifo_re;
    logic       trecieve;
    logic       tsent;
    logic       t0;
    logic       t1;
    logic       t2;
    logic       t3;
    logic       t4;
    logic       t5;
    logic       t6;
    logic       t7;

    modport master (
        input  fifo_empty, fifo_dout, trecieve,
        output fifo_re, tsent, t0, t1, t2, t3, t4, t5, t6, t7
    );

    modport slave (
        output fifo_empty, fifo_dout, trecieve,
        input  fifo_re, tsent, t0, t1, t2, t3, t4, t5, t6, t7
    );
endinterface

// File: rtl/fifo_to_between.sv
// Transmit side of the parallel "between" link: pops a FIFO byte, folds it into a
// bit-serial CRC-8 (x^8+x^2+x+1), then sends it under a 4-phase tsent/trecieve handshake.
module fifo_to_between #(
    parameter int         TIMEOUT  = 1023,
    parameter logic [7:0] CRC_INIT = 8'h00
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  crc_clear,
    fifo_to_between_if.master     bus,
    output logic [7:0]            CRC,
    output logic                  isFinish,
    output logic [3:0]            error,
    output logic [15:0]           byte_count
);

    localparam int          TW      = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TO_LAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;
    localparam bit          TO_EN   = (TIMEOUT > 0);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_READ    = 3'd1,
        S_LATCH   = 3'd2,
        S_CRC     = 3'd3,
        S_SEND    = 3'd4,
        S_RELEASE = 3'd5
    } state_t;

    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
        logic fb;
        fb = crc[7] ^ din;
        return {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    endfunction

    state_t          r_state;
    state_t          w_next;
    logic [7:0]      r_crc,    w_crc;
    logic [7:0]      r_byte,   w_byte;
    logic [2:0]      r_idx,    w_idx;
    logic [TW-1:0]   r_tcnt,   w_tcnt;
    logic [2:0]      r_err,    w_err;
    logic [15:0]     r_count,  w_count;
    logic            r_tsent,  w_tsent;
    logic [7:0]      r_tbits,  w_tbits;
    logic            r_fifo_re, w_fifo_re;
    logic            r_finish;
    logic            w_finish;
    logic            w_timeout;

    // The counter value seen on the last allowed wait cycle ends the handshake edge.
    assign w_timeout = TO_EN && (r_tcnt == TO_LAST);
    assign w_finish  = (w_next == S_IDLE);

    // Next-state and next-output logic; everything holds unless enable is high.
    always_comb begin
        w_next    = r_state;
        w_crc     = r_crc;
        w_byte    = r_byte;
        w_idx     = r_idx;
        w_tcnt    = r_tcnt;
        w_err     = r_err;
        w_count   = r_count;
        w_tsent   = r_tsent;
        w_tbits   = r_tbits;
        w_fifo_re = 1'b0;
        if (enable) begin
            case (r_state)
                S_IDLE: begin
                    w_tsent = 1'b0;
                    if (bus.trecieve) begin
                        w_err[2] = 1'b1;
                    end else begin
                        w_err[2] = r_err[2];
                    end
                    // A CRC reload wins over starting a byte in the same cycle.
                    if (crc_clear) begin
                        w_crc  = CRC_INIT;
                        w_next = S_IDLE;
                    end else if (!bus.fifo_empty) begin
                        w_next    = S_READ;
                        w_fifo_re = 1'b1;
                    end else begin
                        w_next = S_IDLE;
                    end
                end
                S_READ: begin
                    w_next = S_LATCH;
                end
                S_LATCH: begin
                    w_byte = bus.fifo_dout;
                    w_idx  = 3'd7;
                    w_next = S_CRC;
                end
                S_CRC: begin
                    w_crc = crc8_step(r_crc, r_byte[r_idx]);
                    // Present the data bits early so they are settled before tsent rises.
                    if (r_idx == 3'd7) begin
                        w_tbits = r_byte;
                    end else begin
                        w_tbits = r_tbits;
                    end
                    if (r_idx == 3'd0) begin
                        w_next  = S_SEND;
                        w_tsent = 1'b1;
                        w_tcnt  = '0;
                    end else begin
                        w_idx  = r_idx - 3'd1;
                        w_next = S_CRC;
                    end
                end
                S_SEND: begin
                    if (bus.trecieve) begin
                        w_tsent = 1'b0;
                        w_tcnt  = '0;
                        w_next  = S_RELEASE;
                    end else if (w_timeout) begin
                        w_err[0] = 1'b1;
                        w_tsent  = 1'b0;
                        w_next   = S_IDLE;
                    end else begin
                        w_tcnt = r_tcnt + TW'(1);
                        w_next = S_SEND;
                    end
                end
                S_RELEASE: begin
                    if (!bus.trecieve) begin
                        w_count = r_count + 16'd1;
                        w_next  = S_IDLE;
                    end else if (w_timeout) begin
                        w_err[1] = 1'b1;
                        w_next   = S_IDLE;
                    end else begin
                        w_tcnt = r_tcnt + TW'(1);
                        w_next = S_RELEASE;
                    end
                end
                default: begin
                    w_tsent = 1'b0;
                    w_next  = S_IDLE;
                end
            endcase
        end else begin
            w_next = r_state;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_crc     <= CRC_INIT;
            r_byte    <= 8'h00;
            r_idx     <= 3'd0;
            r_tcnt    <= '0;
            r_err     <= 3'b000;
            r_count   <= 16'd0;
            r_tsent   <= 1'b0;
            r_tbits   <= 8'h00;
            r_fifo_re <= 1'b0;
            r_finish  <= 1'b1;
        end else begin
            r_crc     <= w_crc;
            r_byte    <= w_byte;
            r_idx     <= w_idx;
            r_tcnt    <= w_tcnt;
            r_err     <= w_err;
            r_count   <= w_count;
            r_tsent   <= w_tsent;
            r_tbits   <= w_tbits;
            r_fifo_re <= w_fifo_re;
            r_finish  <= w_finish;
        end
    end

    assign bus.fifo_re = r_fifo_re;
    assign bus.tsent   = r_tsent;
    assign bus.t0      = r_tbits[7];
    assign bus.t1      = r_tbits[6];
    assign bus.t2      = r_tbits[5];
    assign bus.t3      = r_tbits[4];
    assign bus.t4      = r_tbits[3];
    assign bus.t5      = r_tbits[2];
    assign bus.t6      = r_tbits[1];
    assign bus.t7      = r_tbits[0];
    assign CRC         = r_crc;
    assign isFinish    = r_finish;
    assign error       = {1'b0, r_err};
    assign byte_count  = r_count;

endmodule

// File: tb/tb_fifo_to_between.sv
// Directed plus randomized bench for fifo_to_between with a FIFO model, a receiver
// model and a byte-wise CRC-8 reference.
module tb_fifo_to_between;
    localparam int TIMEOUT = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        crc_clear;
    logic [7:0]  CRC;
    logic        isFinish;
    logic [3:0]  error;
    logic [15:0] byte_count;

    fifo_to_between_if bus ();

    fifo_to_between #(.TIMEOUT(TIMEOUT), .CRC_INIT(8'h00)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .crc_clear  (crc_clear),
        .bus        (bus),
        .CRC        (CRC),
        .isFinish   (isFinish),
        .error      (error),
        .byte_count (byte_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference CRC: whole byte XORed in, then eight MSB-first shifts.
    function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] b);
        logic [7:0] c;
        c = crc ^ b;
        for (int k = 0; k < 8; k++) begin
            c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
    endfunction

    // FIFO model: read data appears the cycle after a pop strobe.
    logic [7:0] fifo_q[$];
    always @(posedge clk) begin
        if (bus.fifo_re === 1'b1 && fifo_q.size() > 0) begin
            bus.fifo_dout <= fifo_q.pop_front();
        end
        bus.fifo_empty <= (fifo_q.size() == 0);
    end

    // Receiver model with programmable ack / release delays.
    logic rx_q = 1'b0;
    logic rx_force = 1'b0;
    logic never_ack = 1'b0;
    int   ack_delay = 2;
    int   rel_delay = 1;
    int   ack_cnt = 0;
    int   rel_cnt = 0;
    assign bus.trecieve = rx_q | rx_force;
    always @(posedge clk) begin
        if (reset) begin
            rx_q <= 1'b0; ack_cnt <= 0; rel_cnt <= 0;
        end else if (bus.tsent === 1'b1 && !rx_q) begin
            if (!never_ack && ack_cnt + 1 >= ack_delay) begin
                rx_q <= 1'b1; ack_cnt <= 0;
            end else begin
                ack_cnt <= ack_cnt + 1;
            end
        end else if (bus.tsent !== 1'b1 && rx_q) begin
            if (rel_cnt + 1 >= rel_delay) begin
                rx_q <= 1'b0; rel_cnt <= 0;
            end else begin
                rel_cnt <= rel_cnt + 1;
            end
        end else begin
            ack_cnt <= 0; rel_cnt <= 0;
        end
    end

    // Monitor: pop strobes, tsent runs, captured bytes and data stability under tsent.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    logic [7:0] w_tb;
    assign w_tb = {bus.t0, bus.t1, bus.t2, bus.t3, bus.t4, bus.t5, bus.t6, bus.t7};
    logic       prev_tsent = 1'b0;
    logic [7:0] prev_tb = 8'h00;
    logic [7:0] sent_q[$];
    int rises = 0, hi_len = 0, unstable = 0, re_cnt = 0, re_cyc = 0, rise_cyc = 0;
    always @(negedge clk) begin
        if (bus.fifo_re === 1'b1) begin
            re_cnt = re_cnt + 1;
            re_cyc = cyc;
        end
        if (bus.tsent === 1'b1) begin
            if (!prev_tsent) begin
                sent_q.push_back(w_tb);
                rises    = rises + 1;
                rise_cyc = cyc;
                hi_len   = 1;
            end else begin
                hi_len = hi_len + 1;
                if (w_tb !== prev_tb) unstable = unstable + 1;
            end
        end
        prev_tsent = (bus.tsent === 1'b1);
        prev_tb    = w_tb;
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_sent(input string tag, input logic [7:0] exp);
        logic [31:0] got;
        if (sent_q.size() > 0) begin
            got = 32'(sent_q.pop_front());
        end else begin
            got = 32'hDEAD;
        end
        check(tag, got, 32'(exp));
    endtask

    task automatic wait_byte(input string tag, input int re0);
        bit done;
        done = 1'b0;
        for (int k = 0; k < 300 && !done; k++) begin
            step();
            if (re_cnt > re0 && isFinish === 1'b1) done = 1'b1;
        end
        check({tag, "_done"}, 32'(done), 32'd1);
    endtask

    task automatic run_byte(input logic [7:0] b, input string tag);
        int re0;
        re0 = re_cnt;
        fifo_q.push_back(b);
        wait_byte(tag, re0);
    endtask

    task automatic wait_tsent(input string tag);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            step();
            if (bus.tsent === 1'b1) seen = 1'b1;
        end
        check({tag, "_tsent_seen"}, 32'(seen), 32'd1);
    endtask

    logic [7:0] exp_crc;
    logic [7:0] rnd_bytes[16];
    int         re0;
    bit         done;

    initial begin
        reset = 1'b1; enable = 1'b1; crc_clear = 1'b0;
        repeat (3) step();
        check("rst_fifo_re", 32'(bus.fifo_re), 32'd0);
        check("rst_tsent", 32'(bus.tsent), 32'd0);
        check("rst_tbits", 32'(w_tb), 32'd0);
        check("rst_crc", 32'(CRC), 32'h00);
        check("rst_finish", 32'(isFinish), 32'd1);
        check("rst_error", 32'(error), 32'd0);
        check("rst_count", 32'(byte_count), 32'd0);
        reset = 1'b0;
        step(); step();

        // Single byte 0xA5 with a 2-cycle ack.
        exp_crc = 8'h00;
        run_byte(8'hA5, "a5");
        exp_crc = crc8_byte(exp_crc, 8'hA5);
        check("a5_crc_model", 32'(CRC), 32'(exp_crc));
        check("a5_crc_value", 32'(CRC), 32'h72);
        check("a5_pops", 32'(re_cnt), 32'd1);
        check_sent("a5_tbits", 8'hA5);
        check("a5_count", 32'(byte_count), 32'd1);
        check("a5_latency", 32'(rise_cyc - re_cyc), 32'd10);
        check("a5_stable", 32'(unstable), 32'd0);

        // Second byte folds into the running CRC.
        run_byte(8'h01, "b01");
        exp_crc = crc8_byte(exp_crc, 8'h01);
        check("b01_crc_model", 32'(CRC), 32'(exp_crc));
        check("b01_crc_value", 32'(CRC), 32'h5E);
        check("b01_count", 32'(byte_count), 32'd2);
        check("b01_rises", 32'(rises), 32'd2);
        check_sent("b01_tbits", 8'h01);

        // crc_clear wins over a pending byte.
        crc_clear = 1'b1;
        re0 = re_cnt;
        fifo_q.push_back(8'h01);
        repeat (4) step();
        check("clr_crc", 32'(CRC), 32'h00);
        check("clr_no_pop", 32'(re_cnt), 32'(re0));
        check("clr_finish", 32'(isFinish), 32'd1);
        crc_clear = 1'b0;
        wait_byte("clr", re0);
        exp_crc = crc8_byte(8'h00, 8'h01);
        check("clr_crc_after", 32'(CRC), 32'(exp_crc));
        check("clr_count", 32'(byte_count), 32'd3);
        check_sent("clr_tbits", 8'h01);

        // Receiver never acks: SEND times out after TIMEOUT cycles.
        never_ack = 1'b1;
        run_byte(8'h3C, "to");
        exp_crc = crc8_byte(exp_crc, 8'h3C);
        check("to_hi_len", 32'(hi_len), 32'(TIMEOUT));
        check("to_error", 32'(error), 32'b0001);
        check("to_count", 32'(byte_count), 32'd3);
        check("to_crc", 32'(CRC), 32'(exp_crc));
        check("to_tsent", 32'(bus.tsent), 32'd0);
        check_sent("to_tbits", 8'hA5 ^ 8'h99);

        // Enable drops mid-CRC and mid-SEND freeze the CRC and the timeout.
        crc_clear = 1'b1; step(); crc_clear = 1'b0;
        check("en_crc_cleared", 32'(CRC), 32'h00);
        re0 = re_cnt;
        fifo_q.push_back(8'hA5);
        done = 1'b0;
        for (int k = 0; k < 50 && !done; k++) begin
            step();
            if (re_cnt > re0) done = 1'b1;
        end
        check("en_pop_seen", 32'(done), 32'd1);
        step(); step();
        enable = 1'b0; repeat (5) step(); enable = 1'b1;
        wait_tsent("en");
        step(); step();
        enable = 1'b0; repeat (5) step(); enable = 1'b1;
        wait_byte("en", re0);
        check("en_crc", 32'(CRC), 32'h72);
        check("en_hi_len", 32'(hi_len), 32'(TIMEOUT + 5));
        check("en_pops", 32'(re_cnt), 32'(re0 + 1));
        check("en_error", 32'(error), 32'b0001);
        check("en_count", 32'(byte_count), 32'd3);
        check_sent("en_tbits", 8'hA5);
        never_ack = 1'b0;

        // Receiver holds ack too long: RELEASE timeout, then ack seen in IDLE.
        rel_delay = 20;
        run_byte(8'h5A, "rel");
        exp_crc = crc8_byte(8'h72, 8'h5A);
        repeat (25) step();
        check("rel_error", 32'(error), 32'b0111);
        check("rel_count", 32'(byte_count), 32'd3);
        check("rel_crc", 32'(CRC), 32'(exp_crc));
        check("rel_ack_low", 32'(bus.trecieve), 32'd0);
        check_sent("rel_tbits", 8'h5A);
        rel_delay = 1;

        // Reset clears errors; then a randomized stream with random enable and delays.
        reset = 1'b1; step(); reset = 1'b0; step();
        check("rst2_error", 32'(error), 32'd0);
        check("rst2_count", 32'(byte_count), 32'd0);
        check("rst2_crc", 32'(CRC), 32'h00);
        sent_q.delete();
        exp_crc = 8'h00;
        re0 = re_cnt;
        for (int i = 0; i < 16; i++) begin
            rnd_bytes[i] = 8'($urandom_range(0, 255));
            fifo_q.push_back(rnd_bytes[i]);
            exp_crc = crc8_byte(exp_crc, rnd_bytes[i]);
        end
        done = 1'b0;
        for (int k = 0; k < 3000 && !done; k++) begin
            step();
            enable    = ($urandom_range(0, 3) != 0);
            ack_delay = int'($urandom_range(1, 4));
            rel_delay = int'($urandom_range(1, 4));
            if (fifo_q.size() == 0 && byte_count == 16'd16 && isFinish === 1'b1) done = 1'b1;
        end
        enable = 1'b1;
        step();
        check("rnd_done", 32'(done), 32'd1);
        check("rnd_count", 32'(byte_count), 32'd16);
        check("rnd_crc", 32'(CRC), 32'(exp_crc));
        check("rnd_error", 32'(error), 32'd0);
        check("rnd_pops", 32'(re_cnt), 32'(re0 + 16));
        check("rnd_stable", 32'(unstable), 32'd0);
        for (int i = 0; i < 16; i++) begin
            check_sent($sformatf("rnd_tbits_%0d", i), rnd_bytes[i]);
        end

        // Reset in the middle of SEND drops tsent immediately and loses the byte.
        never_ack = 1'b1;
        fifo_q.push_back(8'h77);
        wait_tsent("rs");
        step();
        reset = 1'b1; step();
        check("rs_tsent", 32'(bus.tsent), 32'd0);
        check("rs_crc", 32'(CRC), 32'h00);
        check("rs_finish", 32'(isFinish), 32'd1);
        check("rs_error", 32'(error), 32'd0);
        check("rs_count", 32'(byte_count), 32'd0);
        reset = 1'b0; never_ack = 1'b0;
        re0 = re_cnt;
        repeat (20) step();
        check("rs_no_pop", 32'(re_cnt), 32'(re0));
        check("rs_idle", 32'(isFinish), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
